// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles every fetch-stage signal except clk and rst_n.
//   master : the driver of the fetch stage (hazard/branch logic, program loader)
//            and the reader of the IF/ID outputs.
//   slave  : the fetch stage itself.
//   Signals:
//     stall, redirect, redirect_pc          control into fetch
//     imem_we, imem_waddr, imem_wdata       instruction-memory program-load port
//     fetch_pc                              PC being read this cycle
//     if_id_instr, if_id_pc, if_id_pc_plus1 IF/ID register and derived PC+1
//     if_id_rs, if_id_rt, if_id_rd          pre-split register indices
//     if_id_valid, halted                   bubble flag and halt status
// ----------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int PC_W = 8
);
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_we;
    logic [PC_W-1:0] imem_waddr;
    logic [31:0]     imem_wdata;

    logic [PC_W-1:0] fetch_pc;
    logic [31:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc;
    logic [PC_W-1:0] if_id_pc_plus1;
    logic [3:0]      if_id_rs;
    logic [3:0]      if_id_rt;
    logic [3:0]      if_id_rd;
    logic            if_id_valid;
    logic            halted;

    modport master (
        output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        input  fetch_pc, if_id_instr, if_id_pc, if_id_pc_plus1,
               if_id_rs, if_id_rt, if_id_rd, if_id_valid, halted
    );

    modport slave (
        input  stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        output fetch_pc, if_id_instr, if_id_pc, if_id_pc_plus1,
               if_id_rs, if_id_rt, if_id_rd, if_id_valid, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: PC register, IMEM_DEPTH x 32 instruction memory
//   (combinational read, synchronous write) and the IF/ID pipeline register.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (IMEM contents are not cleared)
//     bus    fetch_stage_if.slave: stall/redirect control, IMEM write port,
//            fetch_pc and IF/ID outputs (see fetch_stage_if.sv)
//   Edge priority: redirect > halted > stall > normal fetch.
//   Optional feature macro: FETCH_HALT_EN -- an instruction with opcode
//   [31:28]==4'hF halts fetch after being latched; only redirect or reset
//   resumes. When undefined, 4'hF is an ordinary word and halted is 0.
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          PC_W       = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    logic [31:0]     r_imem [IMEM_DEPTH];

    state_t          r_state,       w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc,    w_fetch_pc_nxt;
    logic [31:0]     r_if_id_instr, w_if_id_instr_nxt;
    logic [PC_W-1:0] r_if_id_pc,    w_if_id_pc_nxt;
    logic            r_if_id_valid, w_if_id_valid_nxt;

    logic [31:0]     w_imem_rd;
    logic            w_halt_hit;

    // Program-load port. No reset, so contents survive rst_n. Because the read
    // below is combinational off the current array, a same-cycle write to
    // fetch_pc lets IF/ID capture the old word; the new one is seen next cycle.
    always_ff @(posedge clk) begin
        if (bus.imem_we)
            r_imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    assign w_imem_rd = r_imem[r_fetch_pc];

`ifdef FETCH_HALT_EN
    assign w_halt_hit = (w_imem_rd[31:28] == 4'hF);
`else
    assign w_halt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= '0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_valid_nxt = r_if_id_valid;

        if (bus.redirect) begin
            // Flush: one bubble, target fetched on the following edge.
            // Redirect also releases a halt and overrides stall.
            w_state_nxt       = ST_RUN;
            w_fetch_pc_nxt    = bus.redirect_pc;
            w_if_id_instr_nxt = NOP_WORD;
            w_if_id_pc_nxt    = r_fetch_pc;
            w_if_id_valid_nxt = 1'b0;
        end else if (r_state == ST_HALT) begin
            // Halted: PC frozen, stall irrelevant, bubbles stream into decode.
            w_if_id_instr_nxt = NOP_WORD;
            w_if_id_valid_nxt = 1'b0;
        end else if (!bus.stall) begin
            w_if_id_instr_nxt = w_imem_rd;
            w_if_id_pc_nxt    = r_fetch_pc;
            w_if_id_valid_nxt = 1'b1;
            w_fetch_pc_nxt    = r_fetch_pc + PC_W'(1);   // wraps silently
            if (w_halt_hit)
                w_state_nxt = ST_HALT;
        end
    end

    assign bus.fetch_pc       = r_fetch_pc;
    assign bus.if_id_instr    = r_if_id_instr;
    assign bus.if_id_pc       = r_if_id_pc;
    assign bus.if_id_pc_plus1 = r_if_id_pc + PC_W'(1);
    assign bus.if_id_rs       = r_if_id_instr[23:20];
    assign bus.if_id_rt       = r_if_id_instr[19:16];
    assign bus.if_id_rd       = r_if_id_instr[15:12];
    assign bus.if_id_valid    = r_if_id_valid;

`ifdef FETCH_HALT_EN
    assign bus.halted = (r_state == ST_HALT);
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_W(8)) bus ();

    fetch_stage #(.IMEM_DEPTH(256), .PC_W(8), .NOP_WORD(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = a;
        bus.imem_wdata = d;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    task automatic redir(input logic [7:0] tgt);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        tick();
        bus.redirect    = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_we     = 1'b0;
        bus.imem_waddr  = '0;
        bus.imem_wdata  = '0;

        // program load under reset: filler word = address, then test words
        for (int i = 0; i < 256; i++) wr(8'(i), 32'(i));
        wr(8'h00, 32'h0012_3000);
        wr(8'h01, 32'h0045_6000);
        wr(8'h02, 32'h0078_9000);
        wr(8'h03, 32'h00AB_C000);
        wr(8'h05, 32'hF000_0000);

        chk("rst_fetch_pc", 32'(bus.fetch_pc), 32'h0);
        chk("rst_instr",    bus.if_id_instr,   32'h0);
        chk("rst_pc",       32'(bus.if_id_pc), 32'h0);
        chk("rst_valid",    32'(bus.if_id_valid), 32'h0);
        chk("rst_halted",   32'(bus.halted),   32'h0);

        // sequential fetch 0..3
        rst_n = 1'b1;
        tick();
        chk("e1_pc",    32'(bus.if_id_pc), 32'h0);
        chk("e1_valid", 32'(bus.if_id_valid), 32'h1);
        chk("e1_instr", bus.if_id_instr, 32'h0012_3000);
        tick();
        chk("e2_pc", 32'(bus.if_id_pc), 32'h1);
        chk("e2_rs", 32'(bus.if_id_rs), 32'h4);
        chk("e2_rt", 32'(bus.if_id_rt), 32'h5);
        chk("e2_rd", 32'(bus.if_id_rd), 32'h6);
        tick();
        chk("e3_pc", 32'(bus.if_id_pc), 32'h2);
        tick();
        chk("e4_pc",     32'(bus.if_id_pc), 32'h3);
        chk("e4_plus1",  32'(bus.if_id_pc_plus1), 32'h4);
        chk("e4_valid",  32'(bus.if_id_valid), 32'h1);

        // restart, then stall 3 cycles after if_id_pc==1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("pre_stall_pc", 32'(bus.if_id_pc), 32'h1);
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_fetch_pc", 32'(bus.fetch_pc), 32'h2);
            chk("stall_instr",    bus.if_id_instr, 32'h0045_6000);
        end
        bus.stall = 1'b0;
        tick();
        chk("unstall_pc",       32'(bus.if_id_pc), 32'h2);
        chk("unstall_fetch_pc", 32'(bus.fetch_pc), 32'h3);

        // redirect wins over stall, one bubble
        bus.stall = 1'b1;
        redir(8'h10);
        bus.stall = 1'b0;
        bus.redirect_pc = 8'h55;   // must be ignored without redirect
        chk("redir_valid",    32'(bus.if_id_valid), 32'h0);
        chk("redir_instr",    bus.if_id_instr, 32'h0);
        chk("redir_fetch_pc", 32'(bus.fetch_pc), 32'h10);
        chk("redir_if_pc",    32'(bus.if_id_pc), 32'h3);
        tick();
        chk("tgt_pc",       32'(bus.if_id_pc), 32'h10);
        chk("tgt_valid",    32'(bus.if_id_valid), 32'h1);
        chk("tgt_instr",    bus.if_id_instr, 32'h10);
        chk("tgt_fetch_pc", 32'(bus.fetch_pc), 32'h11);

        // PC wrap
        redir(8'hFE);
        chk("wrap_bubble", 32'(bus.if_id_valid), 32'h0);
        tick();
        chk("wrap_pc_fe", 32'(bus.if_id_pc), 32'hFE);
        chk("wrap_v_fe",  32'(bus.if_id_valid), 32'h1);
        tick();
        chk("wrap_pc_ff", 32'(bus.if_id_pc), 32'hFF);
        chk("wrap_p1_ff", 32'(bus.if_id_pc_plus1), 32'h00);
        tick();
        chk("wrap_pc_00", 32'(bus.if_id_pc), 32'h00);
        chk("wrap_v_00",  32'(bus.if_id_valid), 32'h1);
        chk("wrap_i_00",  bus.if_id_instr, 32'h0012_3000);
        tick();
        chk("wrap_pc_01", 32'(bus.if_id_pc), 32'h01);

        // write to the address being fetched: old word captured
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 8'h02;
        bus.imem_wdata = 32'h0CDE_F000;
        tick();
        bus.imem_we    = 1'b0;
        chk("wcol_old", bus.if_id_instr, 32'h0078_9000);
        redir(8'h02);
        tick();
        chk("wcol_new", bus.if_id_instr, 32'h0CDE_F000);
        chk("wcol_pc",  32'(bus.if_id_pc), 32'h2);

        // opcode 4'hF at address 5
        redir(8'h04);
        tick();
        chk("h_pc4",  32'(bus.if_id_pc), 32'h4);
        chk("h_hlt4", 32'(bus.halted), 32'h0);
        tick();
        chk("h_instr5", bus.if_id_instr, 32'hF000_0000);
        chk("h_valid5", 32'(bus.if_id_valid), 32'h1);
        chk("h_fpc5",   32'(bus.fetch_pc), 32'h6);
`ifdef FETCH_HALT_EN
        chk("h_halted", 32'(bus.halted), 32'h1);
        tick();
        chk("h_bub_valid", 32'(bus.if_id_valid), 32'h0);
        chk("h_bub_instr", bus.if_id_instr, 32'h0);
        chk("h_hold_fpc",  32'(bus.fetch_pc), 32'h6);
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        chk("h_stall_fpc", 32'(bus.fetch_pc), 32'h6);
        chk("h_still",     32'(bus.halted), 32'h1);
`else
        chk("h_off_halted", 32'(bus.halted), 32'h0);
        tick();
        chk("h_off_pc6",  32'(bus.if_id_pc), 32'h6);
        chk("h_off_v6",   32'(bus.if_id_valid), 32'h1);
        chk("h_off_fpc",  32'(bus.fetch_pc), 32'h7);
`endif
        redir(8'h00);
        chk("h_clr_halted", 32'(bus.halted), 32'h0);
        chk("h_clr_fpc",    32'(bus.fetch_pc), 32'h0);
        tick();
        chk("h_resume_pc", 32'(bus.if_id_pc), 32'h0);
        chk("h_resume_v",  32'(bus.if_id_valid), 32'h1);

        // asynchronous reset in the middle of a stall at fetch_pc 0x22
        bus.stall = 1'b1;
        redir(8'h22);
        tick();
        chk("ms_fpc", 32'(bus.fetch_pc), 32'h22);
        #3 rst_n = 1'b0;
        #1;
        chk("ms_rst_fpc",   32'(bus.fetch_pc), 32'h0);
        chk("ms_rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("ms_rst_instr", bus.if_id_instr, 32'h0);
        chk("ms_rst_pc",    32'(bus.if_id_pc), 32'h0);
        chk("ms_rst_halt",  32'(bus.halted), 32'h0);
        #2 rst_n = 1'b1;
        bus.stall = 1'b0;
        tick();
        chk("ms_restart_pc",    32'(bus.if_id_pc), 32'h0);
        chk("ms_restart_instr", bus.if_id_instr, 32'h0012_3000);
        chk("ms_restart_valid", 32'(bus.if_id_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/register-file stage.
- Holds the PC and a 256-word instruction memory, and drives the IF/ID pipeline register.
- Supplies decode with the latched instruction and the pre-split rs/rt/rd register indices, plus a valid bit.
- Supports a stall from hazard logic and a branch/jump redirect that flushes the IF/ID register.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words; word addressed.
- PC_W, 8, PC width; log2(IMEM_DEPTH).
- NOP_WORD, 32'h0000_0000, value loaded into IF/ID on flush or reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hold PC and IF/ID contents.
- redirect  in  1  branch/jump taken; load redirect_pc and flush IF/ID.
- redirect_pc  in  PC_W  target word address.
- imem_we  in  1  synchronous instruction-memory write strobe (program load).
- imem_waddr  in  PC_W  write address.
- imem_wdata  in  32  write data.
- fetch_pc  out  PC_W  current PC (address being read this cycle).
- if_id_instr  out  32  latched instruction.
- if_id_pc  out  PC_W  PC of the latched instruction.
- if_id_pc_plus1  out  PC_W  if_id_pc+1, modulo 2^PC_W.
- if_id_rs  out  4  if_id_instr[23:20].
- if_id_rt  out  4  if_id_instr[19:16].
- if_id_rd  out  4  if_id_instr[15:12].
- if_id_valid  out  1  latched instruction is real, not a bubble.
- halted  out  1  fetch halted (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-stall):
  - fetch_pc=0, if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0, halted=0.
  - Instruction memory contents are NOT cleared.
- Instruction memory read is combinational at fetch_pc.
- Instruction memory write on the rising edge when imem_we=1.
- Write-to-same-address-as-fetch_pc in the same cycle: the IF/ID register captures the OLD word; the new word is visible from the next cycle.
- Per rising edge, priority highest first:
  1. redirect=1 (overrides stall): fetch_pc<=redirect_pc; if_id_instr<=NOP_WORD; if_id_valid<=0; if_id_pc<=fetch_pc.
  2. stall=1: fetch_pc and all if_id_* hold.
  3. otherwise: if_id_instr<=imem[fetch_pc]; if_id_pc<=fetch_pc; if_id_valid<=1; fetch_pc<=fetch_pc+1.
- PC wrap: fetch_pc increments 255 -> 0 silently; no flag.
- Latency: the word at address A appears on if_id_instr one edge after fetch_pc==A with no stall and no redirect.
- The first valid instruction after reset appears after the first non-stalled edge.
- The redirect target is fetched on the edge after the redirect edge; exactly one bubble per redirect.
- if_id_rs/rt/rd and if_id_pc_plus1 are combinational decodes of the registered values; no extra latency.
- redirect_pc is sampled only when redirect=1.
- stall held indefinitely is legal; state is frozen with no drift.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - When the instruction being latched into IF/ID has opcode [31:28]==4'hF, it is latched normally with valid=1, and halted<=1 on the same edge.
  - While halted=1: fetch_pc holds, and each following edge loads NOP_WORD with if_id_valid=0.
  - stall has no further effect while halted.
  - halted is cleared only by reset or by redirect; redirect clears halted and behaves per rule 1.
- Not defined:
  - Opcode 4'hF is fetched like any other word.
  - halted is tied to 0.

Test Plan:
- Load imem[0..3]=32'h0012_3000, 32'h0045_6000, 32'h0078_9000, 32'h00AB_C000; release reset; run 4 edges.
  - Expected: if_id_pc 0,1,2,3 on successive edges; valid=1 throughout.
  - Edge 2: rs=4, rt=5, rd=6.
  - Edge 4: if_id_pc_plus1=4.
- Assert stall for 3 cycles after if_id_pc=1.
  - Expected: fetch_pc stays 2; if_id_instr stays 32'h0045_6000.
  - On release, next edge gives if_id_pc=2.
- redirect=1 with redirect_pc=8'h10, asserted together with stall=1.
  - Expected: next edge gives valid=0, instr=0, fetch_pc=8'h10.
  - Following edge: if_id_pc=8'h10, valid=1.
- Set redirect_pc=8'hFE, then free-run.
  - Expected: if_id_pc sequence FE, FF, 00, 01; no valid gap at the wrap.
- Drop rst_n mid-stall with fetch_pc=8'h22.
  - Expected: outputs go to reset values immediately, without waiting for a clock edge; imem contents retained; fetch restarts at 0.
- With FETCH_HALT_EN defined, imem[5]=32'hF000_0000.
  - Expected: halted=1 after that word is latched; fetch_pc stays 6; valid=0 afterwards.
  - redirect to 0 resumes fetch with halted=0.
